channel_run_ctrl: RTL and testbench

Run sequencer for the ISI channel simulation path. It accepts a start command with a symbol count and pulls PAM-4 symbols from a source over a valid/ready handshake. It maps each symbol to a signed level and drives the channel model's sample/valid input, then flushes the channel's pipeline with zero samples. It forwards only the aligned channel outputs downstream, counts traffic, and reports done, abort or timeout.

---
 rtl/channel_run_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_channel_run_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_run_ctrl.sv
// -----------------------------------------------------------------------------
// channel_run_ctrl
//
// Run sequencer for the ISI channel simulation path. A start command latches a
// symbol count N. PAM-4 symbols are then pulled from a source over valid/ready,
// mapped to signed levels and driven into the channel model. The channel
// pipeline is then flushed with CHANNEL_LATENCY zero samples. The first
// CHANNEL_LATENCY channel outputs are dropped and the next N are forwarded.
// The run ends with done, or with an aborted pulse, or with a sticky
// timeout_err when the channel stops answering during the drain phase.
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   start            run request, sampled only while idle
//   num_symbols      symbols in the run, latched on start
//   abort            terminate the current run (ignored while idle)
//   sym_in*          PAM-4 symbol source, valid/ready handshake
//   chan_signal_in   signed sample to the channel
//   chan_in_valid    valid for chan_signal_in
//   chan_signal_out  signed sample from the channel
//   chan_out_valid   valid for chan_signal_out
//   rx_sample        aligned channel output, registered
//   rx_valid         valid for rx_sample
//   busy             high whenever a run is in progress
//   done / aborted   one-cycle completion / abort pulses
//   timeout_err      sticky; cleared by reset or by the next accepted start
//   sent_count       symbols accepted in the current or last run
//   recv_count       rx_valid pulses in the current or last run
// -----------------------------------------------------------------------------
module channel_run_ctrl #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int CHANNEL_LATENCY   = 2,
    parameter int COUNT_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic        [COUNT_WIDTH-1:0]       num_symbols,
    input  logic                                abort,
    input  logic        [1:0]                   sym_in,
    input  logic                                sym_in_valid,
    output logic                                sym_in_ready,
    output logic signed [SIGNAL_RESOLUTION-1:0] chan_signal_in,
    output logic                                chan_in_valid,
    input  logic signed [SIGNAL_RESOLUTION-1:0] chan_signal_out,
    input  logic                                chan_out_valid,
    output logic signed [SIGNAL_RESOLUTION-1:0] rx_sample,
    output logic                                rx_valid,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted,
    output logic                                timeout_err,
    output logic        [COUNT_WIDTH-1:0]       sent_count,
    output logic        [COUNT_WIDTH-1:0]       recv_count
);

    localparam int SR      = SIGNAL_RESOLUTION;
    localparam int WR      = SIGNAL_RESOLUTION + 2;
    localparam int FLUSH_W = $clog2(CHANNEL_LATENCY + 1);
    localparam int DRAIN_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FLUSH_W-1:0] LAT_N      = FLUSH_W'(CHANNEL_LATENCY);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(CHANNEL_LATENCY - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    // Level arithmetic is done two bits wider than the sample, then saturated.
    localparam logic signed [WR-1:0] HALF_W  = WR'(SYMBOL_SEPERATION / 2);
    localparam logic signed [WR-1:0] THREE_W = WR'(3);
    localparam logic signed [WR-1:0] SAT_MAX = {3'b000, {(SR-1){1'b1}}};
    localparam logic signed [WR-1:0] SAT_MIN = {3'b111, {(SR-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q,       state_d;
    logic [COUNT_WIDTH-1:0]  n_q,           n_d;
    logic [COUNT_WIDTH-1:0]  sent_q,        sent_d;
    logic [COUNT_WIDTH-1:0]  recv_q,        recv_d;
    logic [FLUSH_W-1:0]      flush_cnt_q,   flush_cnt_d;
    logic [FLUSH_W-1:0]      disc_cnt_q,    disc_cnt_d;
    logic [DRAIN_W-1:0]      drain_cnt_q,   drain_cnt_d;
    logic                    terr_q,        terr_d;
    logic signed [SR-1:0]    chan_sig_q,    chan_sig_d;
    logic                    chan_vld_q,    chan_vld_d;
    logic signed [SR-1:0]    rx_sample_q,   rx_sample_d;
    logic                    rx_valid_q,    rx_valid_d;
    logic                    done_q,        done_d;
    logic                    aborted_q,     aborted_d;

    logic active;

    // (2*sym - 3) * SEPERATION/2, saturated to the sample width.
    function automatic logic signed [SR-1:0] level_of(input logic [1:0] sym);
        logic signed [WR-1:0] odd;
        logic signed [WR-1:0] wide;
        odd  = $signed({{(SR-1){1'b0}}, sym, 1'b0}) - THREE_W;
        wide = odd * HALF_W;
        if (wide > SAT_MAX) begin
            level_of = SAT_MAX[SR-1:0];
        end else if (wide < SAT_MIN) begin
            level_of = SAT_MIN[SR-1:0];
        end else begin
            level_of = wide[SR-1:0];
        end
    endfunction

    // Abort pre-empts any handshake in the same cycle.
    assign sym_in_ready = (state_q == S_RUN) && !abort;
    assign busy         = (state_q != S_IDLE);
    assign active       = (state_q == S_RUN) || (state_q == S_FLUSH) ||
                          (state_q == S_DRAIN);

    always_comb begin
        // NOTE: every _d gets a default before any branch so that no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        n_d         = n_q;
        sent_d      = sent_q;
        recv_d      = recv_q;
        flush_cnt_d = flush_cnt_q;
        disc_cnt_d  = disc_cnt_q;
        drain_cnt_d = drain_cnt_q;
        terr_d      = terr_q;
        chan_sig_d  = '0;
        chan_vld_d  = 1'b0;
        rx_sample_d = '0;
        rx_valid_d  = 1'b0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        // Output alignment: drop the channel's warm-up outputs, then forward
        // exactly N. recv_count advances on the same edge that raises rx_valid.
        if (active && !abort && chan_out_valid) begin
            if (disc_cnt_q != LAT_N) begin
                disc_cnt_d = disc_cnt_q + FLUSH_ONE;
            end else if (recv_q != n_q) begin
                rx_valid_d  = 1'b1;
                rx_sample_d = chan_signal_out;
                recv_d      = recv_q + CNT_ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d         = num_symbols;
                    sent_d      = '0;
                    recv_d      = '0;
                    disc_cnt_d  = '0;
                    flush_cnt_d = '0;
                    drain_cnt_d = '0;
                    terr_d      = 1'b0;
                    if (num_symbols != '0) begin
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (sym_in_valid) begin
                    chan_vld_d = 1'b1;
                    chan_sig_d = level_of(sym_in);
                    sent_d     = sent_q + CNT_ONE;
                    if (sent_q == n_q - CNT_ONE) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end

            S_FLUSH: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    chan_vld_d = 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FLUSH_ONE;
                    end
                end
            end

            S_DRAIN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (recv_q == n_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    terr_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            sent_q      <= '0;
            recv_q      <= '0;
            flush_cnt_q <= '0;
            disc_cnt_q  <= '0;
            drain_cnt_q <= '0;
            terr_q      <= 1'b0;
            chan_sig_q  <= '0;
            chan_vld_q  <= 1'b0;
            rx_sample_q <= '0;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register, independent of order.
            state_q     <= state_d;
            n_q         <= n_d;
            sent_q      <= sent_d;
            recv_q      <= recv_d;
            flush_cnt_q <= flush_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            terr_q      <= terr_d;
            chan_sig_q  <= chan_sig_d;
            chan_vld_q  <= chan_vld_d;
            rx_sample_q <= rx_sample_d;
            rx_valid_q  <= rx_valid_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign chan_signal_in = chan_sig_q;
    assign chan_in_valid  = chan_vld_q;
    assign rx_sample      = rx_sample_q;
    assign rx_valid       = rx_valid_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign timeout_err    = terr_q;
    assign sent_count     = sent_q;
    assign recv_count     = recv_q;

endmodule

// File: tb/tb_channel_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_channel_run_ctrl
//
// Directed bench for channel_run_ctrl. Stimulus tasks push the expected
// channel-input samples (value and cycle) and the expected rx samples into
// queues; a monitor pops and compares whenever the DUT raises chan_in_valid or
// rx_valid. The channel is a pure CHANNEL_LATENCY-deep delay line whose
// contents are preset to a marker value so warm-up outputs are recognisable.
// -----------------------------------------------------------------------------
module tb_channel_run_ctrl;

    localparam int SR  = 8;
    localparam int CW  = 16;
    localparam int LAT = 2;
    localparam int TMO = 16;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [CW-1:0]        num_symbols = '0;
    logic                 abort = 1'b0;
    logic [1:0]           sym_in = '0;
    logic                 sym_in_valid = 1'b0;
    logic signed [SR-1:0] chan_signal_out = '0;
    logic                 chan_out_valid = 1'b0;

    logic                 sym_in_ready;
    logic signed [SR-1:0] chan_signal_in;
    logic                 chan_in_valid;
    logic signed [SR-1:0] rx_sample;
    logic                 rx_valid;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 timeout_err;
    logic [CW-1:0]        sent_count;
    logic [CW-1:0]        recv_count;

    channel_run_ctrl #(
        .SIGNAL_RESOLUTION (SR),
        .SYMBOL_SEPERATION (56),
        .CHANNEL_LATENCY   (LAT),
        .COUNT_WIDTH       (CW),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .num_symbols     (num_symbols),
        .abort           (abort),
        .sym_in          (sym_in),
        .sym_in_valid    (sym_in_valid),
        .sym_in_ready    (sym_in_ready),
        .chan_signal_in  (chan_signal_in),
        .chan_in_valid   (chan_in_valid),
        .chan_signal_out (chan_signal_out),
        .chan_out_valid  (chan_out_valid),
        .rx_sample       (rx_sample),
        .rx_valid        (rx_valid),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .timeout_err     (timeout_err),
        .sent_count      (sent_count),
        .recv_count      (recv_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int cyc;
    } chan_exp_t;

    chan_exp_t chan_q[$];
    int        rx_q[$];
    int        lvl_tab[4] = '{-84, -28, 28, 84};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int last_done_cyc = -1;
    int last_exp_cyc = 0;
    bit chan_en = 1'b1;
    logic signed [SR-1:0] line [LAT];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter: a sample presented after posedge k is seen with cyc == k.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Channel model: pure delay by LAT input valids.
    initial forever begin
        @(posedge clk);
        #1;
        if (chan_in_valid === 1'b1 && chan_en) begin
            chan_signal_out = line[LAT-1];
            for (int i = LAT - 1; i > 0; i--) line[i] = line[i-1];
            line[0] = chan_signal_in;
            chan_out_valid = 1'b1;
        end else begin
            chan_out_valid = 1'b0;
            chan_signal_out = '0;
        end
    end

    // Monitor / scoreboard.
    initial begin
        chan_exp_t e;
        int        r;
        forever begin
            @(negedge clk);
            if (chan_in_valid === 1'b1) begin
                if (chan_q.size() == 0) begin
                    check("chan_in_extra", chan_in_valid, 0);
                end else begin
                    e = chan_q.pop_front();
                    check("chan_in_level", chan_signal_in, e.val);
                    check("chan_in_cycle", cyc, e.cyc);
                end
            end
            if (rx_valid === 1'b1) begin
                if (rx_q.size() == 0) begin
                    check("rx_extra", rx_valid, 0);
                end else begin
                    r = rx_q.pop_front();
                    check("rx_sample", rx_sample, r);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (aborted === 1'b1) abort_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    task automatic chan_reset();
        for (int i = 0; i < LAT; i++) line[i] = 8'sd111;
    endtask

    task automatic start_run(input int n, input bit with_abort);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        num_symbols = CW'(n);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
    endtask

    task automatic send(input int sym, input int gap);
        bit        ok;
        chan_exp_t e;
        ok = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            sym_in_valid = 1'b0;
        end
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            sym_in = 2'(sym);
            sym_in_valid = 1'b1;
            #1;
            if (sym_in_ready) begin
                ok = 1'b1;
                e.val = lvl_tab[sym];
                e.cyc = cyc + 1;
                last_exp_cyc = e.cyc;
                chan_q.push_back(e);
            end
        end
        check("sym_accept", ok, 1);
    endtask

    task automatic push_flush();
        chan_exp_t e;
        for (int k = 1; k <= LAT; k++) begin
            e.val = 0;
            e.cyc = last_exp_cyc + k;
            chan_q.push_back(e);
        end
        last_exp_cyc = last_exp_cyc + LAT;
    endtask

    task automatic end_send();
        @(negedge clk);
        sym_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) seen = 1'b1;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic check_all_zero(input string t);
        check({t, "_flags"}, int'({sym_in_ready, chan_in_valid, rx_valid, busy,
                                   done, aborted, timeout_err}), 0);
        check({t, "_samples"}, int'({chan_signal_in, rx_sample}), 0);
        check({t, "_counts"}, int'({sent_count, recv_count}), 0);
    endtask

    task automatic run_end(input string t, input int ns, input int nr,
                           input int d0, input int a0, input int dd, input int ad);
        repeat (3) @(negedge clk);
        #1;
        check({t, "_done_pulses"}, done_cnt - d0, dd);
        check({t, "_abort_pulses"}, abort_cnt - a0, ad);
        check({t, "_sent"}, sent_count, ns);
        check({t, "_recv"}, recv_count, nr);
        check({t, "_busy"}, busy, 0);
        check({t, "_chan_left"}, chan_q.size(), 0);
        check({t, "_rx_left"}, rx_q.size(), 0);
    endtask

    initial begin
        int d0;
        int a0;
        int flush_last;

        // Reset state.
        chan_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Back-to-back symbols 0..3, then two flush zeros.
        chan_reset();
        d0 = done_cnt; a0 = abort_cnt;
        start_run(4, 1'b0);
        check("t1_busy", busy, 1);
        rx_q.push_back(-84); rx_q.push_back(-28); rx_q.push_back(28); rx_q.push_back(84);
        send(0, 0); send(1, 0); send(2, 0); send(3, 0);
        push_flush();
        end_send();
        wait_done(60);
        run_end("t1", 4, 4, d0, a0, 1, 0);

        // Source stalls every other cycle.
        chan_reset();
        d0 = done_cnt; a0 = abort_cnt;
        start_run(3, 1'b0);
        rx_q.push_back(28); rx_q.push_back(-84); rx_q.push_back(84);
        send(2, 1); send(0, 1); send(3, 1);
        push_flush();
        end_send();
        wait_done(60);
        run_end("t2", 3, 3, d0, a0, 1, 0);

        // N = 0 with abort in the same cycle: start wins, done next cycle.
        d0 = done_cnt; a0 = abort_cnt;
        start_run(0, 1'b1);
        check("t3_done_now", done, 1);
        check("t3_busy", busy, 0);
        check("t3_no_abort", aborted, 0);
        @(negedge clk);
        #1;
        check("t3_done_once", done, 0);
        run_end("t3", 0, 0, d0, a0, 1, 0);

        // Silent channel: timeout after TMO drain cycles.
        chan_en = 1'b0;
        chan_reset();
        d0 = done_cnt; a0 = abort_cnt;
        start_run(2, 1'b0);
        send(1, 0); send(2, 0);
        push_flush();
        flush_last = last_exp_cyc;
        end_send();
        wait_done(60);
        check("t4_done_cycle", last_done_cyc, flush_last + TMO);
        check("t4_timeout_set", timeout_err, 1);
        run_end("t4", 2, 0, d0, a0, 1, 0);
        check("t4_timeout_sticky", timeout_err, 1);

        chan_en = 1'b1;
        chan_reset();
        d0 = done_cnt; a0 = abort_cnt;
        start_run(1, 1'b0);
        check("t4_timeout_cleared", timeout_err, 0);
        rx_q.push_back(84);
        send(3, 0);
        push_flush();
        end_send();
        wait_done(60);
        run_end("t4b", 1, 1, d0, a0, 1, 0);
        check("t4b_timeout", timeout_err, 0);

        // Abort in RUN after 2 of 5 symbols; start while busy is ignored.
        chan_reset();
        d0 = done_cnt; a0 = abort_cnt;
        start_run(5, 1'b0);
        send(0, 0); send(1, 0);
        @(negedge clk);
        sym_in_valid = 1'b0;
        start = 1'b1;
        num_symbols = CW'(7);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        sym_in = 2'd2;
        sym_in_valid = 1'b1;
        #1;
        check("t5_ready_on_abort", sym_in_ready, 0);
        @(negedge clk);
        abort = 1'b0;
        sym_in_valid = 1'b0;
        #1;
        check("t5_aborted", aborted, 1);
        check("t5_idle", busy, 0);
        repeat (3) @(negedge clk);
        run_end("t5", 2, 0, d0, a0, 0, 1);

        // Reset in the middle of FLUSH, then a fresh run.
        chan_reset();
        d0 = done_cnt; a0 = abort_cnt;
        start_run(2, 1'b0);
        send(1, 0); send(2, 0);
        @(negedge clk);
        rstn = 1'b0;
        sym_in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("t6_midreset");
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_no_abort", abort_cnt - a0, 0);

        chan_reset();
        d0 = done_cnt; a0 = abort_cnt;
        start_run(2, 1'b1);
        check("t6_start_wins", busy, 1);
        rx_q.push_back(84); rx_q.push_back(-84);
        send(3, 0); send(0, 0);
        push_flush();
        end_send();
        wait_done(60);
        run_end("t6b", 2, 2, d0, a0, 1, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
